fetch_stage: RTL and testbench

//  Instruction fetch; feeds decode_stage. Holds the PC and issues one word read at a time to instruction memory.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipeline_pkg
// Description : Shared types and constants for the instruction pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam int ADDR_W      = 32;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : PC, single-outstanding instruction-memory fetch and a
//               one-entry buffer feeding decode; applies decode redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int                    ADDR_WIDTH        = 32,
  parameter int                    INSTRUCTION_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR      = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ADDR_WIDTH-1:0]        imem_addr,
  output logic                         imem_req_done,
  input  logic                         imem_req_stall,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data,
  input  logic                         imem_resp_fault,
  input  logic                         imem_resp_valid,
  input  logic                         redirect,
  input  logic [ADDR_WIDTH-1:0]        redirect_target,
  output logic                         done_next,
  input  logic                         next_stall,
  output logic [ADDR_WIDTH-1:0]        program_count,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_data,
  output logic                         instruction_data_valid
);

  fetch_state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]        pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]        req_pc_q, req_pc_d;
  logic                         outstanding_q, outstanding_d;
  logic                         stale_q, stale_d;
  logic                         active_q;
  logic                         buf_valid_q, buf_valid_d;
  logic [ADDR_WIDTH-1:0]        buf_pc_q, buf_pc_d;
  logic [INSTRUCTION_WIDTH-1:0] buf_data_q, buf_data_d;
  logic                         buf_ok_q, buf_ok_d;

  logic transfer_next;
  logic req_accept;
  logic resp_hit;
  logic target_misaligned;

  assign transfer_next     = buf_valid_q && !next_stall;
  // active_q keeps the request line low through reset and its release cycle
  assign imem_req_done     = active_q && (state_q == FETCH) && !outstanding_q &&
                             (!buf_valid_q || transfer_next);
  assign req_accept        = imem_req_done && !imem_req_stall;
  assign resp_hit          = imem_resp_valid && outstanding_q;
  assign target_misaligned = (redirect_target[1:0] != 2'b00);

  assign imem_addr              = pc_q;
  assign done_next              = buf_valid_q;
  assign program_count          = buf_pc_q;
  assign instruction_data       = buf_data_q;
  assign instruction_data_valid = buf_ok_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q;
    buf_valid_d   = buf_valid_q;
    buf_pc_d      = buf_pc_q;
    buf_data_d    = buf_data_q;
    buf_ok_d      = buf_ok_q;

    if (transfer_next) begin
      buf_valid_d = 1'b0;
    end

    if (req_accept) begin
      outstanding_d = 1'b1;
      req_pc_d      = pc_q;
      pc_d          = pc_q + ADDR_WIDTH'(INSTR_BYTES);
      state_d       = WAIT;
    end

    if (resp_hit) begin
      outstanding_d = 1'b0;
      stale_d       = 1'b0;
      if (!stale_q) begin
        buf_valid_d = 1'b1;
        buf_pc_d    = req_pc_q;
        buf_data_d  = imem_resp_data;
        buf_ok_d    = !imem_resp_fault;
        state_d     = imem_resp_fault ? HALT : FETCH;
      end
    end

    // Redirect overrides everything above; an in-flight request becomes stale
    if (redirect) begin
      pc_d        = redirect_target;
      buf_valid_d = 1'b0;
      state_d     = FETCH;
      if (req_accept || (outstanding_q && !imem_resp_valid)) begin
        outstanding_d = 1'b1;
        stale_d       = 1'b1;
      end else begin
        outstanding_d = 1'b0;
        stale_d       = 1'b0;
      end
      if (target_misaligned) begin
        buf_valid_d = 1'b1;
        buf_pc_d    = redirect_target;
        buf_data_d  = '0;
        buf_ok_d    = 1'b0;
        state_d     = HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_VECTOR;
      req_pc_q      <= RESET_VECTOR;
      outstanding_q <= 1'b0;
      stale_q       <= 1'b0;
      active_q      <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_pc_q      <= '0;
      buf_data_q    <= '0;
      buf_ok_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      active_q      <= 1'b1;
      buf_valid_q   <= buf_valid_d;
      buf_pc_q      <= buf_pc_d;
      buf_data_q    <= buf_data_d;
      buf_ok_q      <= buf_ok_d;
    end
  end

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage with a latency-configurable
//               instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_req_done;
  logic        imem_req_stall;
  logic [31:0] imem_resp_data;
  logic        imem_resp_fault;
  logic        imem_resp_valid;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        done_next;
  logic        next_stall;
  logic [31:0] program_count;
  logic [31:0] instruction_data;
  logic        instruction_data_valid;

  fetch_stage #(
    .ADDR_WIDTH       (32),
    .INSTRUCTION_WIDTH(32),
    .RESET_VECTOR     (32'h0)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .imem_addr             (imem_addr),
    .imem_req_done         (imem_req_done),
    .imem_req_stall        (imem_req_stall),
    .imem_resp_data        (imem_resp_data),
    .imem_resp_fault       (imem_resp_fault),
    .imem_resp_valid       (imem_resp_valid),
    .redirect              (redirect),
    .redirect_target       (redirect_target),
    .done_next             (done_next),
    .next_stall            (next_stall),
    .program_count         (program_count),
    .instruction_data      (instruction_data),
    .instruction_data_valid(instruction_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic ok; } entry_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  entry_t      exp_entry_q[$];
  logic [31:0] exp_addr_q[$];
  pend_t       pend_q[$];
  int          acc_cyc_q[$];
  int          pop_cyc_q[$];

  int          n_checks = 0;
  int          n_fails  = 0;
  int          n_pops   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  logic        fault_en = 1'b0;
  logic [31:0] fault_addr = 32'h0;

  entry_t      mon_e;
  logic [31:0] mon_a;
  pend_t       mon_p;
  pend_t       mem_p;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_target = t;
    redirect        = 1'b1;
    tick();
    redirect        = 1'b0;
  endtask

  // Let decode accept n entries, then stall it again
  task automatic run_entries(input int n);
    int target;
    int k;
    target     = n_pops + n;
    k          = 0;
    next_stall = 1'b0;
    while (n_pops < target && k < 200) begin
      tick();
      k++;
    end
    next_stall = 1'b1;
    if (n_pops < target) check_eq("entries_timeout", 64'(n_pops), 64'(target));
  endtask

  task automatic push_entry(input logic [31:0] pc, input logic ok);
    entry_t e;
    e.pc = pc;
    e.ok = ok;
    exp_entry_q.push_back(e);
  endtask

  // Request and entry monitors
  always @(negedge clk) begin
    if (rst) begin
      if (imem_req_done && !imem_req_stall) begin
        check_eq("req_expected", 64'(exp_addr_q.size() != 0), 64'd1);
        if (exp_addr_q.size() != 0) begin
          mon_a = exp_addr_q.pop_front();
          check_eq("req_addr", 64'(imem_addr), 64'(mon_a));
        end
        mon_p.addr = imem_addr;
        mon_p.due  = cyc + lat;
        pend_q.push_back(mon_p);
        acc_cyc_q.push_back(cyc);
      end
      if (done_next && !next_stall) begin
        check_eq("entry_expected", 64'(exp_entry_q.size() != 0), 64'd1);
        if (exp_entry_q.size() != 0) begin
          mon_e = exp_entry_q.pop_front();
          check_eq("entry_pc", 64'(program_count), 64'(mon_e.pc));
          check_eq("entry_valid", 64'(instruction_data_valid), 64'(mon_e.ok));
          if (mon_e.ok) check_eq("entry_data", 64'(instruction_data), 64'(mem_word(mon_e.pc)));
        end
        pop_cyc_q.push_back(cyc);
        n_pops++;
      end
    end
  end

  // Instruction memory: one-cycle response pulse, lat cycles after handshake
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_fault = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      imem_resp_valid = 1'b0;
      imem_resp_fault = 1'b0;
      if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
        mem_p           = pend_q.pop_front();
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_p.addr);
        imem_resp_fault = fault_en && (mem_p.addr == fault_addr);
      end
    end
  end

  initial begin
    int k;
    rst             = 1'b0;
    imem_req_stall  = 1'b0;
    redirect        = 1'b0;
    redirect_target = '0;
    next_stall      = 1'b1;

    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_done_next", 64'(done_next), 64'd0);
    check_eq("rst_req_done", 64'(imem_req_done), 64'd0);
    check_eq("rst_imem_addr", 64'(imem_addr), 64'd0);
    check_eq("rst_pc_out", 64'(program_count), 64'd0);
    check_eq("rst_instr_valid", 64'(instruction_data_valid), 64'd0);

    // Sequential fetch with 1-cycle memory
    foreach (exp_addr_q[i]) exp_addr_q.delete(i);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'hC);
    push_entry(32'h0, 1'b1);
    push_entry(32'h4, 1'b1);
    push_entry(32'h8, 1'b1);
    tick();
    rst = 1'b1;
    run_entries(3);
    check_eq("first_latency", 64'(pop_cyc_q[0] - acc_cyc_q[0]), 64'd2);
    check_eq("cadence_1", 64'(pop_cyc_q[1] - pop_cyc_q[0]), 64'd2);
    check_eq("cadence_2", 64'(pop_cyc_q[2] - pop_cyc_q[1]), 64'd2);

    // Decode stall holds the buffered entry and blocks new requests
    repeat (5) begin
      tick();
      @(negedge clk);
      check_eq("stall_done_next", 64'(done_next), 64'd1);
      check_eq("stall_pc", 64'(program_count), 64'hC);
      check_eq("stall_data", 64'(instruction_data), 64'(mem_word(32'hC)));
      check_eq("stall_no_req", 64'(imem_req_done), 64'd0);
    end
    push_entry(32'hC, 1'b1);
    exp_addr_q.push_back(32'h10);
    run_entries(1);

    // Redirect while a request is outstanding drops its response
    lat = 5;
    push_entry(32'h10, 1'b1);
    exp_addr_q.push_back(32'h14);
    run_entries(1);
    tick();
    exp_addr_q.push_back(32'h100);
    exp_addr_q.push_back(32'h104);
    push_entry(32'h100, 1'b1);
    do_redirect(32'h100);
    run_entries(1);

    // Misaligned redirect: fault entry, then halt until redirected
    lat = 1;
    push_entry(32'h102, 1'b0);
    do_redirect(32'h102);
    run_entries(1);
    next_stall = 1'b0;
    repeat (4) begin
      tick();
      @(negedge clk);
      check_eq("halt_no_req", 64'(imem_req_done), 64'd0);
    end
    exp_addr_q.push_back(32'h200);
    exp_addr_q.push_back(32'h204);
    push_entry(32'h200, 1'b1);
    do_redirect(32'h200);
    run_entries(1);

    // Fault response at 0xC halts fetch
    fault_en   = 1'b1;
    fault_addr = 32'hC;
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'hC);
    push_entry(32'h8, 1'b1);
    push_entry(32'hC, 1'b0);
    do_redirect(32'h8);
    run_entries(2);
    next_stall = 1'b0;
    repeat (4) begin
      tick();
      @(negedge clk);
      check_eq("fault_no_req", 64'(imem_req_done), 64'd0);
    end
    next_stall = 1'b1;
    fault_en   = 1'b0;

    // PC wrap at the top of the address space
    exp_addr_q.push_back(32'hFFFF_FFF8);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    push_entry(32'hFFFF_FFF8, 1'b1);
    push_entry(32'hFFFF_FFFC, 1'b1);
    do_redirect(32'hFFFF_FFF8);
    run_entries(2);
    tick();
    tick();
    check_eq("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);

    // Reset during WAIT; the late response must be ignored
    lat = 6;
    exp_addr_q.push_back(32'h300);
    do_redirect(32'h300);
    tick();
    imem_req_stall = 1'b1;
    rst            = 1'b0;
    tick();
    @(negedge clk);
    check_eq("mid_rst_done_next", 64'(done_next), 64'd0);
    check_eq("mid_rst_req_done", 64'(imem_req_done), 64'd0);
    check_eq("mid_rst_imem_addr", 64'(imem_addr), 64'd0);
    tick();
    rst = 1'b1;
    k   = 0;
    while (pend_q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    check_eq("stale_resp_delivered", 64'(pend_q.size()), 64'd0);
    tick();
    @(negedge clk);
    check_eq("reset_resp_ignored", 64'(done_next), 64'd0);
    lat = 1;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    push_entry(32'h0, 1'b1);
    tick();
    imem_req_stall = 1'b0;
    run_entries(1);
    repeat (3) tick();
    check_eq("final_addr_q_drained", 64'(exp_addr_q.size()), 64'd0);
    check_eq("final_entry_q_drained", 64'(exp_entry_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
